seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameters: none; the operand widths are fixed at a 6-bit dividend and a 3-bit divisor, the inverse operation of the team's 3x3 multiplier.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-005 dividend  input  6  unsigned dividend; sampled only when start is accepted.
REQ-006 divisor  input  3  unsigned divisor; sampled only when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse marking that a result is available.
REQ-009 quotient  output  6  unsigned quotient of the last completed division.
REQ-010 remainder  output  3  unsigned remainder of the last completed division.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed division.

Function
REQ-012 The block SHALL be a three-state machine with states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 SHALL latch the operands, clear the 4-bit partial remainder and the 3-bit step counter, and move to RUN.
REQ-014 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-015 Each RUN cycle SHALL perform one restoring step, MSB first:
- r = {r[2:0], next dividend bit}
- if r >= divisor: subtract divisor from r and set the quotient bit to 1; otherwise set it to 0.
REQ-016 After the 6th step, RUN SHALL move to DONE.
REQ-017 In the same edge, quotient, remainder and dbz SHALL be loaded, with remainder = r[2:0].
REQ-018 Latency: if start is accepted at edge N, done SHALL be high for exactly the cycle following edge N+6 (the cycle in DONE).
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 start while in RUN SHALL be ignored; the inputs are not re-sampled.
REQ-021 quotient, remainder and dbz SHALL hold their values until the next completion; they SHALL NOT change during RUN.
REQ-022 start in DONE SHALL be accepted, which gives back-to-back divisions with a 7-cycle period.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every divisor != 0.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, and clear the internal counter, partial remainder and operand registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-027 With macro SEQ_DIVIDER_DBZ_CHECK_EN defined, divisor=0 at start SHALL go directly from RUN's first cycle to DONE.
- Results: quotient=6'h3F, remainder=0, dbz=1.
- done is high in the cycle after edge N+1.
REQ-028 Without the macro, divisor=0 SHALL run the normal 6-step algorithm.
- Results: quotient=6'h3F, remainder=dividend[2:0].
- dbz SHALL be tied to 0.

Structure
REQ-029 Package seq_divider_pkg SHALL hold the state enum (IDLE/RUN/DONE), the dividend width (6), the divisor width (3) and the step count (6).
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit).

Verification
REQ-031 dividend=45, divisor=7, start one cycle -> busy for 6 cycles, then done pulse with quotient=6, remainder=3.
REQ-032 Exhaustive sweep of dividend 0..63 and divisor 1..7 -> every result satisfies REQ-023; done latency is always 6 edges.
REQ-033 start held high continuously with changing operands -> operands sampled only in IDLE/DONE; results every 7 cycles match the operands sampled at each acceptance.
REQ-034 rst asserted at step 3 of dividend=63, divisor=5 -> outputs zero at once, no done pulse; the next division 63/5 gives 12 r 3.
REQ-035 dividend=42, divisor=0:
- with the macro -> done after 1 step, quotient=63, remainder=0, dbz=1;
- without it -> done after 6 steps, quotient=63, remainder=2, dbz=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the 6-by-3 bit sequential restoring divider.
package seq_divider_pkg;

    localparam int DVD_W = 6;
    localparam int DVS_W = 3;
    localparam int STEPS = 6;
    localparam int REM_W = DVS_W + 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report whether it did.
module div_step
    import seq_divider_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] divisor_ext;

    always_comb begin
        shifted     = {rem_in[REM_W-2:0], bit_in};
        divisor_ext = {1'b0, divisor};
        q_bit       = (shifted >= divisor_ext);
        rem_out     = q_bit ? (shifted - divisor_ext) : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 6/3-bit restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DBZ_CHECK_EN to short-circuit divide-by-zero with dbz=1.
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             dbz
);

    state_t           state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] quotient_q, quotient_d;
    logic [DVS_W-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [REM_W-1:0] step_rem;
    logic             step_bit;

    div_step u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DVD_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // The dividend register doubles as the quotient accumulator: each step
    // shifts out the next dividend bit and shifts in the new quotient bit.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else
`endif
                begin
                    dvd_d = {dvd_q[DVD_W-2:0], step_bit};
                    rem_d = step_rem;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        quotient_d  = {dvd_q[DVD_W-2:0], step_bit};
                        remainder_d = step_rem[DVS_W-1:0];
                        dbz_d       = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: reset, single divisions,
// exhaustive sweep, back-to-back starts, mid-run reset and divide-by-zero.
module tb_seq_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] dividend;
   logic [2:0] divisor;
   logic       busy;
   logic       done;
   logic [5:0] quotient;
   logic [2:0] remainder;
   logic       dbz;

   int totalCount = 0;
   int badCount   = 0;
   int lastQ      = 0;

   seq_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input int actual, input int expected);
      totalCount++;
      if (actual !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Runs one division from IDLE and checks latency, busy length, result hold
   // during the run, the final outputs and that done lasts a single cycle
   task automatic applyStimulus(input logic [5:0] a, input logic [2:0] b,
                                input int expLat, input int expQ,
                                input int expR, input int expDbz);
      int edges;
      int busyCount;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = 6'($urandom);
      divisor  = 3'($urandom);
      edges     = 0;
      busyCount = 0;
      while (!done && edges < 20) begin
         if (busy) busyCount++;
         checkOutput("hold_q", quotient, lastQ);
         @(negedge clk);
         edges++;
      end
      checkOutput("latency", edges, expLat);
      checkOutput("busy_len", busyCount, expLat);
      checkOutput("quotient", quotient, expQ);
      checkOutput("remainder", remainder, expR);
      checkOutput("dbz", dbz, expDbz);
      checkOutput("busy_done", busy, 0);
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
      lastQ = expQ;
   endtask

   // Back-to-back mode operand pattern, a function of the cycle index
   function automatic logic [5:0] b2bDividend(input int k);
      return 6'((k * 11 + 5) % 64);
   endfunction

   function automatic logic [2:0] b2bDivisor(input int k);
      return 3'(k % 7 + 1);
   endfunction

   // Main sequence
   initial begin
      int doneSeen;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_q", quotient, 0);
      checkOutput("rst_r", remainder, 0);
      checkOutput("rst_dbz", dbz, 0);
      rst = 1'b0;

      $display("[TB] directed divisions");
      applyStimulus(6'd45, 3'd7, 6, 6, 3, 0);
      applyStimulus(6'd63, 3'd5, 6, 12, 3, 0);
      applyStimulus(6'd0,  3'd1, 6, 0, 0, 0);
      applyStimulus(6'd63, 3'd1, 6, 63, 0, 0);
      applyStimulus(6'd6,  3'd7, 6, 0, 6, 0);
      applyStimulus(6'd7,  3'd7, 6, 1, 0, 0);
      applyStimulus(6'd20, 3'd3, 6, 6, 2, 0);
      applyStimulus(6'd50, 3'd4, 6, 12, 2, 0);

      $display("[TB] exhaustive sweep");
      for (int a = 0; a < 64; a++) begin
         for (int b = 1; b < 8; b++) begin
            applyStimulus(6'(a), 3'(b), 6, a / b, a % b, 0);
         end
      end

      $display("[TB] start held high");
      for (int k = 0; k <= 28; k++) begin
         @(negedge clk);
         if (k > 0) begin
            if (k % 7 == 0) begin
               checkOutput("b2b_done", done, 1);
               checkOutput("b2b_q", quotient, b2bDividend(k - 7) / b2bDivisor(k - 7));
               checkOutput("b2b_r", remainder, b2bDividend(k - 7) % b2bDivisor(k - 7));
            end else begin
               checkOutput("b2b_nodone", done, 0);
               checkOutput("b2b_busy", busy, 1);
            end
         end
         start    = (k <= 21);
         dividend = b2bDividend(k);
         divisor  = b2bDivisor(k);
      end
      start = 1'b0;
      lastQ = b2bDividend(21) / b2bDivisor(21);

      $display("[TB] reset mid-run");
      applyStimulus(6'd45, 3'd7, 6, 6, 3, 0);
      @(negedge clk);
      start    = 1'b1;
      dividend = 6'd63;
      divisor  = 3'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_q", quotient, 0);
      checkOutput("abort_r", remainder, 0);
      checkOutput("abort_dbz", dbz, 0);
      @(negedge clk);
      rst      = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("abort_nodone", doneSeen, 0);
      lastQ = 0;
      applyStimulus(6'd63, 3'd5, 6, 12, 3, 0);

      $display("[TB] divide by zero");
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
      applyStimulus(6'd42, 3'd0, 1, 63, 0, 1);
`else
      applyStimulus(6'd42, 3'd0, 6, 63, 2, 0);
`endif
      applyStimulus(6'd45, 3'd7, 6, 6, 3, 0);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation timeout");
   end

endmodule
